// File: rtl/dma353_pkg.sv
// Shared definitions for the dma_feeder353 channel: default geometry, trailer marker, FSM states.
package dma353_pkg;

  localparam int unsigned BURST_WORDS_DEF = 16;
  localparam int unsigned FIFO_BURSTS_DEF = 64;
  localparam logic [15:0] PAD_WORD_DEF    = '0;
  localparam logic [15:0] TRAILER_MARK    = 16'hFFFF;

  typedef enum logic [1:0] {
    STREAM,
    PAD,
    TRAILER
  } state_t;

endpackage

// File: rtl/dma_credit353.sv
// Burst credit counter: tracks bursts reserved in the FIFO, saturates at FIFO_BURSTS,
// flags a sticky error on release with no outstanding credit.
module dma_credit353
  import dma353_pkg::*;
#(
  parameter int unsigned FIFO_BURSTS = FIFO_BURSTS_DEF
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       reserve,
  input  logic       burst_rd,
  output logic [6:0] bursts_alloc,
  output logic       err
);

  localparam logic [6:0] ALLOC_MAX = 7'(FIFO_BURSTS);

  always_ff @(posedge clk) begin
    if (clr) begin
      bursts_alloc <= '0;
      err          <= 1'b0;
    end else if (reserve && !burst_rd) begin
      if (bursts_alloc != ALLOC_MAX) bursts_alloc <= bursts_alloc + 7'd1;
    end else if (burst_rd && !reserve) begin
      if (bursts_alloc == '0) err <= 1'b1;
      else                    bursts_alloc <= bursts_alloc - 7'd1;
    end
  end

endmodule

// File: rtl/dma_feeder353.sv
// DMA FIFO feeder: turns a producer word stream into whole padded bursts under burst credit.
// Optional end-of-frame trailer burst enabled by defining DMA_FEEDER_TRAILER_EN.
module dma_feeder353
  import dma353_pkg::*;
#(
  parameter int unsigned BURST_WORDS = BURST_WORDS_DEF,
  parameter int unsigned FIFO_BURSTS = FIFO_BURSTS_DEF,
  parameter logic [15:0] PAD_WORD    = PAD_WORD_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        src_valid,
  input  logic [15:0] src_data,
  input  logic        src_last,
  output logic        src_ready,
  output logic        we,
  output logic [15:0] di,
  input  logic        burst_rd,
  output logic [6:0]  bursts_alloc,
  output logic        frame_done,
  output logic        err
);

  localparam int unsigned   WW        = $clog2(BURST_WORDS);
  localparam logic [WW-1:0] WLAST     = WW'(BURST_WORDS - 1);
  localparam logic [6:0]    ALLOC_MAX = 7'(FIFO_BURSTS);

`ifdef DMA_FEEDER_TRAILER_EN
  localparam state_t END_STATE = TRAILER;
  logic [31:0] fcount;
`else
  localparam state_t END_STATE = STREAM;
`endif

  state_t        state, state_nxt;
  logic [WW-1:0] wcnt;
  logic          clr, credit_ok, accept, issue, final_wr, reserve, last_wr;
  logic [15:0]   wr_data;

  assign clr = rst || !en;

  dma_credit353 #(.FIFO_BURSTS(FIFO_BURSTS)) u_credit (
    .clk          (clk),
    .clr          (clr),
    .reserve      (reserve),
    .burst_rd     (burst_rd),
    .bursts_alloc (bursts_alloc),
    .err          (err)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= STREAM;
      wcnt       <= '0;
      we         <= 1'b0;
      di         <= '0;
      last_wr    <= 1'b0;
      frame_done <= 1'b0;
`ifdef DMA_FEEDER_TRAILER_EN
      fcount     <= '0;
`endif
    end else begin
      state      <= state_nxt;
      we         <= issue;
      last_wr    <= final_wr;
      frame_done <= last_wr;
      if (issue) begin
        di   <= wr_data;
        wcnt <= wcnt + WW'(1);
      end
`ifdef DMA_FEEDER_TRAILER_EN
      // Cleared on the frame's final trailer write so the next frame's first accept counts.
      if (final_wr)    fcount <= '0;
      else if (accept) fcount <= fcount + 32'd1;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      STREAM:  if (accept && src_last) state_nxt = (wcnt == WLAST) ? END_STATE : PAD;
      PAD:     if (wcnt == WLAST) state_nxt = END_STATE;
      TRAILER: if (issue && wcnt == WLAST) state_nxt = STREAM;
      default: state_nxt = STREAM;
    endcase
  end

  always_comb begin
    credit_ok = (wcnt != '0) || (bursts_alloc < ALLOC_MAX);
    src_ready = !clr && (state == STREAM) && credit_ok;
    accept    = src_valid && src_ready;
    issue     = 1'b0;
    wr_data   = src_data;
    final_wr  = 1'b0;
    case (state)
      STREAM: issue = accept;
      PAD: begin
        issue   = 1'b1;
        wr_data = PAD_WORD;
      end
`ifdef DMA_FEEDER_TRAILER_EN
      TRAILER: begin
        issue = credit_ok;
        if (wcnt == '0)         wr_data = TRAILER_MARK;
        else if (wcnt == WW'(1)) wr_data = fcount[31:16];
        else if (wcnt == WW'(2)) wr_data = fcount[15:0];
        else                     wr_data = '0;
      end
`endif
      default: issue = 1'b0;
    endcase
`ifdef DMA_FEEDER_TRAILER_EN
    final_wr = issue && (state == TRAILER) && (wcnt == WLAST);
`else
    final_wr = issue && (wcnt == WLAST) &&
               ((state == PAD) || (state == STREAM && src_last));
`endif
    reserve = issue && (wcnt == '0);
  end

endmodule

// File: tb/tb_dma_feeder353.sv
// Self-checking bench for dma_feeder353: queue-based write model plus directed scenarios.
module tb_dma_feeder353;

`ifdef DMA_FEEDER_TRAILER_EN
  localparam bit TRL = 1'b1;
`else
  localparam bit TRL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, en, src_valid, src_last, burst_rd;
  logic [15:0] src_data;
  logic        src_ready, we, frame_done, err;
  logic [15:0] di;
  logic [6:0]  bursts_alloc;

  always #5 clk = ~clk;

  dma_feeder353 dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .src_valid    (src_valid),
    .src_data     (src_data),
    .src_last     (src_last),
    .src_ready    (src_ready),
    .we           (we),
    .di           (di),
    .burst_rd     (burst_rd),
    .bursts_alloc (bursts_alloc),
    .frame_done   (frame_done),
    .err          (err)
  );

  int checks = 0;
  int errors = 0;

  function void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: every FIFO write the frame rules imply, queued in order, one popped per clock.
  typedef struct {
    logic [15:0] data;
    bit          res;
    bit          fin;
  } ent_t;

  ent_t        q[$];
  int          alloc_m = 0;
  int          pos_m = 0;
  int unsigned fcnt_m = 0;
  bit          err_m = 0, fd_pend = 0, exp_we = 0, exp_fd = 0;
  logic [15:0] exp_di = '0;
  bit          s_clr = 1, s_acc = 0, s_last = 0, s_rd = 0;
  logic [15:0] s_data = '0;
  bit          run = 0;
  int unsigned wr_total = 0, fd_total = 0;

  function bit exp_ready();
    return !rst && en && (q.size() == 0) && (pos_m != 0 || alloc_m < 64);
  endfunction

  function void push_word(input logic [15:0] d, input bit fin);
    ent_t e;
    e.data = d;
    e.res  = (pos_m == 0);
    e.fin  = fin;
    q.push_back(e);
    pos_m = (pos_m + 1) % 16;
  endfunction

  function void finish_frame();
    logic [31:0] c;
    logic [15:0] w;
    while (pos_m != 0) push_word(16'h0000, !TRL && pos_m == 15);
    if (TRL) begin
      c = fcnt_m;
      for (int i = 0; i < 16; i++) begin
        w = (i == 0) ? 16'hFFFF : (i == 1) ? c[31:16] : (i == 2) ? c[15:0] : 16'h0000;
        push_word(w, i == 15);
      end
      fcnt_m = 0;
    end
  endfunction

  always @(posedge clk) begin : model
    bit   res;
    ent_t e;
    if (s_clr) begin
      q.delete();
      alloc_m = 0; err_m = 0; pos_m = 0; fcnt_m = 0;
      fd_pend = 0; exp_we = 0; exp_fd = 0;
    end else begin
      exp_fd  = fd_pend;
      fd_pend = 0;
      res     = 0;
      if (s_acc) begin
        fcnt_m++;
        push_word(s_data, s_last && pos_m == 15 && !TRL);
        if (s_last) finish_frame();
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        exp_we = 1; exp_di = e.data; res = e.res;
        if (e.fin) fd_pend = 1;
      end else begin
        exp_we = 0;
      end
      if (res && !s_rd) begin
        if (alloc_m < 64) alloc_m++;
      end else if (s_rd && !res) begin
        if (alloc_m == 0) err_m = 1;
        else              alloc_m--;
      end
    end
  end

  always @(negedge clk) begin : compare
    if (run) begin
      chk("we", we, exp_we);
      if (exp_we) chk("di", di, exp_di);
      chk("src_ready", src_ready, exp_ready());
      chk("bursts_alloc", bursts_alloc, alloc_m);
      chk("frame_done", frame_done, exp_fd);
      chk("err", err, err_m);
      if (we) wr_total++;
      if (frame_done) fd_total++;
    end
    s_clr  = rst || !en;
    s_acc  = src_valid && exp_ready();
    s_data = src_data;
    s_last = src_last;
    s_rd   = burst_rd;
  end

  task automatic send(input logic [15:0] d, input bit last);
    bit ok = 0;
    src_valid = 1; src_data = d; src_last = last;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (src_ready) begin ok = 1; break; end
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    src_valid = 0; src_last = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    idle(2);
    rst = 0;
  endtask

  int unsigned bw, bf;

  initial begin
    rst = 1; en = 1; src_valid = 0; src_data = '0; src_last = 0; burst_rd = 0;
    idle(2);
    run = 1;
    @(negedge clk);
    chk("rst_we", we, 0);
    chk("rst_alloc", bursts_alloc, 0);
    chk("rst_ready", src_ready, 0);
    chk("rst_err", err, 0);
    @(posedge clk); #1;
    rst = 0;

    // 32 words, last on word 31
    bw = wr_total; bf = fd_total;
    for (int i = 0; i < 32; i++) send(16'(i), i == 31);
    idle(TRL ? 24 : 4);
    chk("t32_alloc", bursts_alloc, TRL ? 3 : 2);
    chk("t32_writes", wr_total - bw, TRL ? 48 : 32);
    chk("t32_fd", fd_total - bf, 1);

    // 5 words, padded
    do_reset();
    bw = wr_total; bf = fd_total;
    for (int i = 0; i < 5; i++) send(16'(i), i == 4);
    idle(40);
    chk("t5_alloc", bursts_alloc, TRL ? 2 : 1);
    chk("t5_writes", wr_total - bw, TRL ? 32 : 16);
    chk("t5_fd", fd_total - bf, 1);

    // fill 64 bursts, then credit block and release
    do_reset();
    for (int i = 0; i < 1024; i++) send(16'(i), 1'b0);
    src_valid = 1; src_data = 16'h0400;
    @(negedge clk);
    chk("full_ready", src_ready, 0);
    chk("full_alloc", bursts_alloc, 64);
    @(posedge clk); #1; burst_rd = 1;
    @(posedge clk); #1; burst_rd = 0;
    @(negedge clk);
    chk("rd_alloc", bursts_alloc, 63);
    chk("rd_ready", src_ready, 1);
    @(posedge clk); #1; src_valid = 0;
    @(negedge clk);
    chk("refill_alloc", bursts_alloc, 64);

    // coincident reservation and release at 10
    do_reset();
    for (int i = 0; i < 160; i++) send(16'(i), 1'b0);
    src_valid = 1; src_data = 16'h00A0; burst_rd = 1;
    @(posedge clk); #1; src_valid = 0; burst_rd = 0;
    @(negedge clk);
    chk("coinc_alloc", bursts_alloc, 10);

    // release at zero credit
    do_reset();
    burst_rd = 1;
    @(posedge clk); #1; burst_rd = 0;
    @(negedge clk);
    chk("under_alloc", bursts_alloc, 0);
    chk("under_err", err, 1);
    idle(5);
    chk("err_sticky", err, 1);
    do_reset();
    @(negedge clk);
    chk("err_cleared", err, 0);

    // reset mid-burst
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) send(16'(i), 1'b0);
    rst = 1;
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    chk("mid_rst_we", we, 0);
    chk("mid_rst_alloc", bursts_alloc, 0);
    @(posedge clk); #1;
    bw = wr_total; bf = fd_total;
    for (int i = 0; i < 5; i++) send(16'h0100 + 16'(i), i == 4);
    idle(40);
    chk("post_rst_writes", wr_total - bw, TRL ? 32 : 16);
    chk("post_rst_fd", fd_total - bf, 1);

`ifdef DMA_FEEDER_TRAILER_EN
    // 20-word frame with trailer
    do_reset();
    bw = wr_total; bf = fd_total;
    for (int i = 0; i < 20; i++) send(16'(i), i == 19);
    idle(40);
    chk("trl_alloc", bursts_alloc, 3);
    chk("trl_writes", wr_total - bw, 48);
    chk("trl_fd", fd_total - bf, 1);
`endif

    run = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
